// File: rtl/chick_pkg.sv
// Shared types and defaults for the Chicken Cha-Cha-Cha board datapath.
package chick_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         N_TILES_DEF   = 16;
  localparam int         PIC_W_DEF     = 3;
  localparam int         POS_W_DEF     = 4;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;

endpackage

// File: rtl/chick_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; exposes only the low OUT_W bits as a picture id.
module chick_lfsr8
  import chick_pkg::*;
#(
  parameter logic [7:0] SEED  = LFSR_SEED_DEF,
  parameter int         OUT_W = PIC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] pic
);

  logic [7:0] state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else begin
      state_reg <= {state_reg[6:0], ^(state_reg & LFSR_TAPS)};
    end
  end

  assign pic = state_reg[OUT_W-1:0];

endmodule

// File: rtl/chick_board_datapath.sv
// Board side of the game: fills the tile RAM from the LFSR, tracks the chicken,
// and answers the control FSM with c (ready), go (card matches) and win.
module chick_board_datapath
  import chick_pkg::*;
#(
  parameter int         N_TILES   = N_TILES_DEF,
  parameter int         PIC_W     = PIC_W_DEF,
  parameter int         POS_W     = POS_W_DEF,
  parameter logic [7:0] LFSR_SEED = chick_pkg::LFSR_SEED_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A,
  input  logic             B,
  input  logic [PIC_W-1:0] sel,
  input  logic             new_game,
  output logic             c,
  output logic             go,
  output logic             win,
  output logic [POS_W-1:0] pos,
  output logic [PIC_W-1:0] show_idx,
  output logic             show_vld
);

  localparam logic [POS_W-1:0] GOAL = POS_W'(N_TILES - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  state_t           state;
  logic [POS_W-1:0] idx;
  logic [PIC_W-1:0] lfsr_pic;
  logic [PIC_W-1:0] sel_meta;
  logic [PIC_W-1:0] sel_s;
  logic             a_prev;
  logic             b_prev;
  logic [PIC_W-1:0] tile [N_TILES];

  wire              a_rise = A & ~a_prev;
  wire              b_rise = B & ~b_prev;
  // Clamp the look-ahead index so it never leaves the array at the goal tile.
  wire [POS_W-1:0]  ahead  = (pos < GOAL) ? pos + ONE : GOAL;
  wire              init_wr = (state == INIT) && !new_game;

  chick_lfsr8 #(
    .SEED  (LFSR_SEED),
    .OUT_W (PIC_W)
  ) u_lfsr (
    .clk   (CLK),
    .rst_n (RST_N),
    .pic   (lfsr_pic)
  );

  always_ff @(posedge CLK) begin
    if (init_wr) begin
      tile[idx] <= lfsr_pic;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= INIT;
      idx      <= '0;
      pos      <= '0;
      c        <= 1'b0;
      go       <= 1'b0;
      win      <= 1'b0;
      show_idx <= '0;
      show_vld <= 1'b0;
      sel_meta <= '0;
      sel_s    <= '0;
      a_prev   <= 1'b0;
      b_prev   <= 1'b0;
    end else begin
      sel_meta <= sel;
      sel_s    <= sel_meta;
      a_prev   <= A;
      b_prev   <= B;
      if (new_game) begin
        state    <= INIT;
        idx      <= '0;
        pos      <= '0;
        c        <= 1'b0;
        go       <= 1'b0;
        win      <= 1'b0;
        show_vld <= 1'b0;
      end else begin
        go  <= (state == PLAY) && (pos < GOAL) && (tile[ahead] == sel_s);
        win <= ((state == PLAY) && (pos == GOAL - ONE)) || (state == DONE);
        case (state)
          INIT: begin
            idx <= idx + ONE;
            if (idx == GOAL) begin
              state <= PLAY;
              c     <= 1'b1;
            end else begin
              c     <= 1'b0;
            end
          end
          PLAY: begin
            c <= 1'b1;
            if (b_rise && (pos < GOAL)) begin
              pos <= pos + ONE;
              if (pos + ONE == GOAL) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            c   <= 1'b1;
            pos <= GOAL;
          end
          default: begin
            state <= INIT;
            c     <= 1'b0;
          end
        endcase
        if (a_rise && (state != INIT)) begin
          show_idx <= sel_s;
          show_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chick_board_datapath.sv
// Directed bench for chick_board_datapath: board fill, go/win timing, edges, new_game.
module tb_chick_board_datapath;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       new_game = 1'b0;
  logic       c;
  logic       go;
  logic       win;
  logic [3:0] pos;
  logic [2:0] show_idx;
  logic       show_vld;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         start;
  logic [7:0] seq [4096];
  int         exp_tile [16];
  int         old_tile [16];

  chick_board_datapath dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .new_game (new_game),
    .c        (c),
    .go       (go),
    .win      (win),
    .pos      (pos),
    .show_idx (show_idx),
    .show_vld (show_vld)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input int expv);
    checks++;
    if (got !== 32'(expv)) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end else begin
      $display("  ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Tile i of a board whose init started after the edge numbered s holds seq[s+i].
  task automatic load_board(input int s);
    for (int i = 0; i < 16; i++) exp_tile[i] = int'(seq[s + i][2:0]);
  endtask

  task automatic step_b();
    B = 1'b1;
    tick();
    B = 1'b0;
    tick();
  endtask

  task automatic probe_go(input int p, input string tag);
    sel = 3'(exp_tile[p + 1]);
    tick(3);
    check($sformatf("%s_go_p%0d", tag, p), go, 1);
  endtask

  initial begin
    seq[0] = 8'hA5;
    for (int k = 1; k < 4096; k++)
      seq[k] = {seq[k-1][6:0], seq[k-1][7] ^ seq[k-1][5] ^ seq[k-1][4] ^ seq[k-1][3]};

    #2;
    check("rst_c", c, 0);
    check("rst_go", go, 0);
    check("rst_win", win, 0);
    check("rst_pos", pos, 0);
    check("rst_show_idx", show_idx, 0);
    check("rst_show_vld", show_vld, 0);
    #10 RST_N = 1'b1;
    load_board(0);

    // Board fill takes exactly 16 edges.
    check("init_c_0", c, 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("init_c_%0d", k), c, 0);
    end
    tick();
    check("init_c_16", c, 1);
    check("play_pos", pos, 0);
    check("play_win", win, 0);

    // go lags a switch change by exactly 3 cycles.
    sel = 3'(exp_tile[1]);
    tick(2);
    check("go_lag2", go, (exp_tile[1] == 0) ? 1 : 0);
    tick();
    check("go_lag3", go, 1);
    sel = 3'(exp_tile[1] ^ 1);
    tick(2);
    check("go_drop_lag2", go, 1);
    tick();
    check("go_drop_lag3", go, 0);

    // A held-high B moves only once.
    B = 1'b1;
    tick();
    check("b_hold_1", pos, 1);
    tick(4);
    check("b_hold_5", pos, 1);
    B = 1'b0;
    tick();
    check("b_low", pos, 1);
    B = 1'b1;
    tick();
    check("b_rise2", pos, 2);
    B = 1'b0;
    tick();
    check("no_show_yet", show_vld, 0);

    for (int p = 2; p < 14; p++) begin
      probe_go(p, "g1");
      check($sformatf("g1_win_p%0d", p), win, 0);
      step_b();
      check($sformatf("g1_pos_p%0d", p + 1), pos, p + 1);
    end
    check("win_at_14", win, 1);
    probe_go(14, "g1");

    // Flip and final move in the same cycle.
    sel = 3'd5;
    tick(3);
    A = 1'b1;
    B = 1'b1;
    tick();
    check("ab_pos", pos, 15);
    check("ab_show_idx", show_idx, 5);
    check("ab_show_vld", show_vld, 1);
    A = 1'b0;
    B = 1'b0;
    tick();
    check("done_go", go, 0);
    check("done_win", win, 1);
    check("done_c", c, 1);
    step_b();
    check("done_sat1", pos, 15);
    step_b();
    check("done_sat2", pos, 15);

    for (int i = 0; i < 16; i++) old_tile[i] = exp_tile[i];

    // new_game from DONE, then again mid-INIT at idx=7 with A held high.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng1_c", c, 0);
    check("ng1_pos", pos, 0);
    check("ng1_show_vld", show_vld, 0);
    check("ng1_win", win, 0);
    tick(7);
    A = 1'b1;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    start = cyc;
    load_board(start);
    tick(15);
    check("ng2_c_15", c, 0);
    tick();
    check("ng2_c_16", c, 1);
    check("ng2_show_vld", show_vld, 0);
    A = 1'b0;
    tick();
    check("ng2_show_vld_a_drop", show_vld, 0);

    sel = 3'(old_tile[1]);
    tick(3);
    check("g2_oldtile_go", go, (old_tile[1] == exp_tile[1]) ? 1 : 0);
    for (int p = 0; p < 9; p++) begin
      probe_go(p, "g2");
      step_b();
    end
    check("g2_pos9", pos, 9);
    sel = 3'd3;
    tick(3);
    A = 1'b1;
    tick();
    A = 1'b0;
    check("g2_show_idx", show_idx, 3);
    check("g2_show_vld", show_vld, 1);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    start = cyc;
    load_board(start);
    check("ng3_pos", pos, 0);
    check("ng3_c", c, 0);
    check("ng3_show_vld", show_vld, 0);
    check("ng3_go", go, 0);
    tick(15);
    check("ng3_c_15", c, 0);
    tick();
    check("ng3_c_16", c, 1);
    probe_go(0, "g3");
    step_b();
    check("g3_pos1", pos, 1);

    // Asynchronous reset takes effect without a clock edge.
    #2 RST_N = 1'b0;
    #1;
    check("async_pos", pos, 0);
    check("async_c", c, 0);
    check("async_show_vld", show_vld, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
